// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: decodes chip-select framed SPI byte streams from SPI_Slave into
// single-cycle bus write/read strobes and feeds read data back to the slave.
module spi_cmd_decoder #(
    parameter int         ADDR_W     = 8,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] OP_WRITE   = 8'h01,
    parameter logic [7:0] OP_READ    = 8'h02
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_CS_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    output logic              o_Wr_En,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [7:0]        o_Wr_Data,
    input  logic [7:0]        i_Rd_Data,
    output logic              o_Busy,
    output logic              o_Err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic                  cs_meta_r, cs_sync_r, cs_prev_r;
    logic                  cs_fall_s, cs_rise_s, frame_end_s;
    logic                  mode_rd_r, mode_rd_s;
    logic [ADDR_W-1:0]     ptr_r, ptr_s, addr_s, byte_addr_s;
    logic                  wr_en_s, rd_en_s, err_s, tx_dv_s;
    logic [7:0]            wr_data_s, tx_byte_s;
    logic [RD_LATENCY-1:0] rd_pipe_r;

    assign cs_fall_s   = cs_prev_r & ~cs_sync_r;
    assign cs_rise_s   = ~cs_prev_r & cs_sync_r;
    assign frame_end_s = cs_rise_s & (state_r != ST_IDLE);
    assign byte_addr_s = ADDR_W'(i_RX_Byte);

    // CS synchronizer; resetting to "selected" means a frame still in progress
    // when reset releases cannot fake a falling edge.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_meta_r <= 1'b0;
            cs_sync_r <= 1'b0;
            cs_prev_r <= 1'b0;
        end else begin
            cs_meta_r <= i_CS_n;
            cs_sync_r <= cs_meta_r;
            cs_prev_r <= cs_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; frame end wins after the current byte has been decoded.
    always_comb begin
        state_s = state_r;
        if (frame_end_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_s = cs_fall_s ? ST_OPCODE : ST_IDLE;
                ST_OPCODE: begin
                    if (i_RX_DV) begin
                        if (i_RX_Byte == OP_WRITE || i_RX_Byte == OP_READ) begin
                            state_s = ST_ADDR;
                        end else begin
                            state_s = ST_DISCARD;
                        end
                    end else begin
                        state_s = ST_OPCODE;
                    end
                end
                ST_ADDR: begin
                    if (i_RX_DV) begin
                        state_s = mode_rd_r ? ST_READ : ST_WRITE;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_WRITE, ST_READ, ST_DISCARD: state_s = state_r;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // Output/datapath decode: strobes, address pointer, mode and error flag.
    always_comb begin
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        addr_s    = o_Addr;
        wr_data_s = o_Wr_Data;
        ptr_s     = ptr_r;
        mode_rd_s = mode_rd_r;
        err_s     = o_Err;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    err_s = 1'b0;
                end else begin
                    err_s = o_Err;
                end
            end
            ST_OPCODE: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == OP_WRITE) begin
                        mode_rd_s = 1'b0;
                    end else if (i_RX_Byte == OP_READ) begin
                        mode_rd_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    mode_rd_s = mode_rd_r;
                end
            end
            ST_ADDR: begin
                if (i_RX_DV && mode_rd_r) begin
                    rd_en_s = 1'b1;
                    addr_s  = byte_addr_s;
                    ptr_s   = byte_addr_s + ADDR_W'(1'b1);
                end else if (i_RX_DV) begin
                    ptr_s = byte_addr_s;
                end else begin
                    ptr_s = ptr_r;
                end
            end
            ST_WRITE: begin
                if (i_RX_DV) begin
                    wr_en_s   = 1'b1;
                    addr_s    = ptr_r;
                    wr_data_s = i_RX_Byte;
                    ptr_s     = ptr_r + ADDR_W'(1'b1);
                end else begin
                    ptr_s = ptr_r;
                end
            end
            ST_READ: begin
                if (i_RX_DV) begin
                    rd_en_s = 1'b1;
                    addr_s  = ptr_r;
                    ptr_s   = ptr_r + ADDR_W'(1'b1);
                end else begin
                    ptr_s = ptr_r;
                end
            end
            ST_DISCARD: ptr_s = ptr_r;
            default:    ptr_s = ptr_r;
        endcase
        // i_Rd_Data is sampled on the RD_LATENCY-th edge after o_Rd_En rises.
        tx_dv_s   = rd_pipe_r[RD_LATENCY-1] & ~frame_end_s;
        tx_byte_s = tx_dv_s ? i_Rd_Data : o_TX_Byte;
    end

    // Datapath registers and the read-return valid pipe (flushed at frame end).
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            ptr_r     <= {ADDR_W{1'b0}};
            mode_rd_r <= 1'b0;
            rd_pipe_r <= {RD_LATENCY{1'b0}};
        end else begin
            ptr_r     <= ptr_s;
            mode_rd_r <= mode_rd_s;
            rd_pipe_r <= frame_end_s ? {RD_LATENCY{1'b0}}
                                     : ((rd_pipe_r << 1'b1) | RD_LATENCY'(rd_en_s));
        end
    end

    // Registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Wr_En   <= 1'b0;
            o_Rd_En   <= 1'b0;
            o_Addr    <= {ADDR_W{1'b0}};
            o_Wr_Data <= 8'h00;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
            o_Busy    <= 1'b0;
            o_Err     <= 1'b0;
        end else begin
            o_Wr_En   <= wr_en_s;
            o_Rd_En   <= rd_en_s;
            o_Addr    <= addr_s;
            o_Wr_Data <= wr_data_s;
            o_TX_DV   <= tx_dv_s;
            o_TX_Byte <= tx_byte_s;
            o_Busy    <= (state_s != ST_IDLE);
            o_Err     <= err_s;
        end
    end

endmodule
